// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-interface stage: MAR/MDR, RAM read/write handshake sequencing,
// memory-mapped keyboard/display registers and the R access-complete pulse.
module lc3_mem_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter logic [15:0] IO_BASE = 16'hFE00
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [15:0] BUS_IN,
   input  logic        LD_MAR,
   input  logic        LD_MDR,
   input  logic        MIO_EN,
   input  logic        R_W,
   output logic [15:0] MDR_OUT,
   output logic        R,
   output logic        MEM_ERR,
   output logic [15:0] RAM_ADDR,
   output logic [15:0] RAM_DIN,
   output logic        RAM_CS,
   output logic        RAM_WE,
   input  logic [15:0] RAM_DOUT,
   input  logic        RAM_READY,
   input  logic [7:0]  KB_DATA,
   input  logic        KB_STROBE,
   output logic        KB_INT,
   output logic [7:0]  DISP_DATA,
   output logic        DISP_VALID,
   input  logic        DISP_ACK
);

   localparam logic [15:0] KbsrAddr = IO_BASE;
   localparam logic [15:0] KbdrAddr = IO_BASE + 16'd2;
   localparam logic [15:0] DsrAddr  = IO_BASE + 16'd4;
   localparam logic [15:0] DdrAddr  = IO_BASE + 16'd6;
   localparam logic [15:0] LastCnt  = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRdIssue,
      StRdWait,
      StWr,
      StIo,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] mar_q, mar_d;
   logic [15:0] mdr_q, mdr_d;
   logic [7:0]  kbdr_q, kbdr_d;
   logic        kbsr15_q, kbsr15_d;
   logic        kbsr14_q, kbsr14_d;
   logic        dsr15_q, dsr15_d;
   logic [7:0]  disp_data_q, disp_data_d;
   logic        disp_valid_q, disp_valid_d;
   logic        err_q, err_d;
   logic        cs_q, cs_d;
   logic        we_q, we_d;
   logic        rw_q, rw_d;
   logic [15:0] cnt_q, cnt_d;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= StIdle;
         mar_q        <= 16'h0000;
         mdr_q        <= 16'h0000;
         kbdr_q       <= 8'h00;
         kbsr15_q     <= 1'b0;
         kbsr14_q     <= 1'b0;
         dsr15_q      <= 1'b1;
         disp_data_q  <= 8'h00;
         disp_valid_q <= 1'b0;
         err_q        <= 1'b0;
         cs_q         <= 1'b0;
         we_q         <= 1'b0;
         rw_q         <= 1'b0;
         cnt_q        <= 16'h0000;
      end else begin
         state_q      <= state_d;
         mar_q        <= mar_d;
         mdr_q        <= mdr_d;
         kbdr_q       <= kbdr_d;
         kbsr15_q     <= kbsr15_d;
         kbsr14_q     <= kbsr14_d;
         dsr15_q      <= dsr15_d;
         disp_data_q  <= disp_data_d;
         disp_valid_q <= disp_valid_d;
         err_q        <= err_d;
         cs_q         <= cs_d;
         we_q         <= we_d;
         rw_q         <= rw_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mar_d        = mar_q;
      mdr_d        = mdr_q;
      kbdr_d       = kbdr_q;
      kbsr15_d     = kbsr15_q;
      kbsr14_d     = kbsr14_q;
      dsr15_d      = dsr15_q;
      disp_data_d  = disp_data_q;
      disp_valid_d = disp_valid_q;
      err_d        = err_q;
      cs_d         = cs_q;
      we_d         = we_q;
      rw_d         = rw_q;
      cnt_d        = cnt_q;

      if (DISP_ACK && disp_valid_q) begin
         disp_valid_d = 1'b0;
         dsr15_d      = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (LD_MAR) mar_d = BUS_IN;
            if (LD_MDR) mdr_d = BUS_IN;
            if (MIO_EN) begin
               rw_d = R_W;
               if (mar_q >= IO_BASE) begin
                  state_d = StIo;
               end else if (!R_W) begin
                  state_d = StRdIssue;
                  cs_d    = 1'b1;
                  we_d    = 1'b0;
               end else begin
                  state_d = StWr;
                  cs_d    = 1'b1;
                  we_d    = 1'b1;
               end
            end
         end
         // RAM_READY may still be high from the previous read; skip it here.
         StRdIssue: begin
            cnt_d   = 16'h0000;
            state_d = StRdWait;
         end
         StRdWait: begin
            if (RAM_READY) begin
               mdr_d   = RAM_DOUT;
               cs_d    = 1'b0;
               state_d = StDone;
            end else if (cnt_q == LastCnt) begin
               err_d   = 1'b1;
               cs_d    = 1'b0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StWr: begin
            cs_d    = 1'b0;
            we_d    = 1'b0;
            state_d = StDone;
         end
         StIo: begin
            if (rw_q) begin
               if (mar_q == KbsrAddr) begin
                  kbsr14_d = mdr_q[14];
               end else if (mar_q == DdrAddr) begin
                  disp_data_d  = mdr_q[7:0];
                  disp_valid_d = 1'b1;
                  dsr15_d      = 1'b0;
               end
            end else begin
               if (mar_q == KbsrAddr) begin
                  mdr_d = {kbsr15_q, kbsr14_q, 14'h0000};
               end else if (mar_q == KbdrAddr) begin
                  mdr_d    = {8'h00, kbdr_q};
                  kbsr15_d = 1'b0;
               end else if (mar_q == DsrAddr) begin
                  mdr_d = {dsr15_q, 15'h0000};
               end else begin
                  mdr_d = 16'h0000;
               end
            end
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A new keystroke overrides the clear from a coincident KBDR read.
      if (KB_STROBE) begin
         kbdr_d   = KB_DATA;
         kbsr15_d = 1'b1;
      end
   end

   assign MDR_OUT    = mdr_q;
   assign R          = (state_q == StDone);
   assign MEM_ERR    = err_q;
   assign RAM_ADDR   = mar_q;
   assign RAM_DIN    = mdr_q;
   assign RAM_CS     = cs_q;
   assign RAM_WE     = we_q;
   assign KB_INT     = kbsr15_q & kbsr14_q;
   assign DISP_DATA  = disp_data_q;
   assign DISP_VALID = disp_valid_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed scenarios plus random accesses
// checked against a transaction-level model of RAM contents and I/O registers.
module tb_lc3_mem_ctrl;

   localparam int          TO      = 16;
   localparam logic [15:0] IO_BASE = 16'hFE00;

   logic        CLK;
   logic        RESET_N;
   logic [15:0] BUS_IN;
   logic        LD_MAR, LD_MDR, MIO_EN, R_W;
   logic [15:0] MDR_OUT;
   logic        R, MEM_ERR;
   logic [15:0] RAM_ADDR, RAM_DIN;
   logic        RAM_CS, RAM_WE;
   logic [15:0] RAM_DOUT;
   logic        RAM_READY;
   logic [7:0]  KB_DATA;
   logic        KB_STROBE;
   logic        KB_INT;
   logic [7:0]  DISP_DATA;
   logic        DISP_VALID;
   logic        DISP_ACK;

   lc3_mem_ctrl #(.TIMEOUT(TO), .IO_BASE(IO_BASE)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .BUS_IN(BUS_IN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
      .MIO_EN(MIO_EN), .R_W(R_W), .MDR_OUT(MDR_OUT), .R(R), .MEM_ERR(MEM_ERR),
      .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_CS(RAM_CS), .RAM_WE(RAM_WE),
      .RAM_DOUT(RAM_DOUT), .RAM_READY(RAM_READY), .KB_DATA(KB_DATA), .KB_STROBE(KB_STROBE),
      .KB_INT(KB_INT), .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID), .DISP_ACK(DISP_ACK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Environment RAM: single-cycle read; ram_mode 0 normal, 1 never ready, 2 ready stuck high
   logic [15:0] ram [0:65535];
   int          ram_mode;
   always @(posedge CLK) begin
      if (RAM_CS && RAM_WE) ram[RAM_ADDR] <= RAM_DIN;
      if (RAM_CS && !RAM_WE) RAM_DOUT <= ram[RAM_ADDR];
      case (ram_mode)
         1:       RAM_READY <= 1'b0;
         2:       RAM_READY <= 1'b1;
         default: RAM_READY <= RAM_CS && !RAM_WE;
      endcase
   end

   // Reference model state
   logic [15:0] ref_mem [logic [15:0]];
   logic        m_kb_full, m_kb_ie, m_disp_ready, m_disp_pend, m_err;
   logic [7:0]  m_kb_data, m_disp_char;
   logic [15:0] m_mdr;

   int n_pass, n_chk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [15:0] init_val(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h1357;
   endfunction

   function automatic logic [15:0] ram_val(input logic [15:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   task automatic model_reset();
      m_kb_full = 0; m_kb_ie = 0; m_kb_data = 8'h00;
      m_disp_ready = 1; m_disp_pend = 0; m_disp_char = 8'h00;
      m_err = 0; m_mdr = 16'h0000;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_io_outs(input string tag);
      chk({tag, "_kbint"}, KB_INT, m_kb_full & m_kb_ie);
      chk({tag, "_dvalid"}, DISP_VALID, m_disp_pend);
      chk({tag, "_ddata"}, DISP_DATA, m_disp_char);
   endtask

   task automatic kb_strobe(input logic [7:0] d);
      KB_DATA = d; KB_STROBE = 1; tick(); KB_STROBE = 0;
      m_kb_data = d; m_kb_full = 1;
   endtask

   task automatic disp_ack();
      DISP_ACK = 1; tick(); DISP_ACK = 0;
      if (m_disp_pend) begin m_disp_pend = 0; m_disp_ready = 1; end
   endtask

   // One complete access; co_strobe pulses KB_STROBE during the I/O cycle.
   task automatic do_access(input logic rw, input logic [15:0] addr, input logic [15:0] data,
                            input logic co_strobe, input logic [7:0] co_data);
      int          lat, exp_lat;
      logic [15:0] off;
      BUS_IN = addr; LD_MAR = 1; tick(); LD_MAR = 0;
      BUS_IN = data; LD_MDR = 1; tick(); LD_MDR = 0;
      chk("ram_addr", RAM_ADDR, addr);
      m_mdr = data;
      off = addr - IO_BASE;
      if (addr >= IO_BASE) begin
         exp_lat = 2;
         if (rw) begin
            if (off == 16'd0) m_kb_ie = data[14];
            else if (off == 16'd6) begin
               m_disp_char = data[7:0]; m_disp_pend = 1; m_disp_ready = 0;
            end
         end else begin
            case (off)
               16'd0:   m_mdr = {m_kb_full, m_kb_ie, 14'h0};
               16'd2:   begin m_mdr = {8'h00, m_kb_data}; m_kb_full = 0; end
               16'd4:   m_mdr = {m_disp_ready, 15'h0};
               default: m_mdr = 16'h0000;
            endcase
         end
         if (co_strobe) begin m_kb_data = co_data; m_kb_full = 1; end
      end else if (rw) begin
         exp_lat = 2;
         ref_mem[addr] = data;
      end else if (ram_mode == 1) begin
         exp_lat = 2 + TO;
         m_err = 1;
      end else begin
         exp_lat = 3;
         m_mdr = ram_val(addr);
      end

      MIO_EN = 1; R_W = rw;
      tick();
      lat = 1;
      chk("cs_cycle1", RAM_CS, addr < IO_BASE);
      chk("we_cycle1", RAM_WE, (addr < IO_BASE) && rw);
      if (co_strobe) begin KB_STROBE = 1; KB_DATA = co_data; end
      while (R !== 1'b1 && lat < 40) begin
         tick();
         KB_STROBE = 0;
         lat++;
      end
      KB_STROBE = 0;
      MIO_EN = 0;
      chk("latency", lat, exp_lat);
      tick();
      chk("r_one_cycle", R, 1'b0);
      chk("cs_idle", RAM_CS, 1'b0);
      chk("mdr", MDR_OUT, m_mdr);
      chk("mem_err", MEM_ERR, m_err);
      check_io_outs("acc");
   endtask

   function automatic logic [15:0] pick_ram_addr();
      if ($urandom_range(0, 3) == 0) return 16'hFDFF - 16'($urandom_range(0, 3));
      return 16'h3000 + 16'($urandom_range(0, 15));
   endfunction

   function automatic logic [15:0] pick_io_addr();
      if ($urandom_range(0, 5) == 0) return 16'hFFFE;
      return IO_BASE + 16'($urandom_range(0, 9));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic r_seen;
      n_pass = 0; n_chk = 0;
      for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));
      ram_mode = 0; RAM_DOUT = 16'h0; RAM_READY = 0;
      BUS_IN = 0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; R_W = 0;
      KB_DATA = 0; KB_STROBE = 0; DISP_ACK = 0;
      model_reset();
      RESET_N = 0;
      #12;
      chk("rst_mdr", MDR_OUT, 16'h0);
      chk("rst_r", R, 1'b0);
      chk("rst_err", MEM_ERR, 1'b0);
      chk("rst_cs", RAM_CS, 1'b0);
      chk("rst_we", RAM_WE, 1'b0);
      chk("rst_addr", RAM_ADDR, 16'h0);
      check_io_outs("rst");
      tick();
      RESET_N = 1;
      tick();

      // Reset in the middle of a never-ready read
      ram_mode = 1;
      BUS_IN = 16'h3000; LD_MAR = 1; tick(); LD_MAR = 0;
      MIO_EN = 1; R_W = 0; tick();
      tick(); tick(); tick();
      chk("rdwait_cs", RAM_CS, 1'b1);
      #2 RESET_N = 0;
      #1 chk("async_rst_cs", RAM_CS, 1'b0);
      MIO_EN = 0;
      r_seen = R;
      for (int i = 0; i < 3; i++) begin tick(); r_seen |= R; end
      RESET_N = 1;
      for (int i = 0; i < 6; i++) begin tick(); r_seen |= R; end
      chk("rst_no_r", r_seen, 1'b0);
      model_reset();
      ram_mode = 0;
      do_access(0, IO_BASE + 16'd4, 16'h5555, 0, 8'h00);

      // Write then read back at x3000
      do_access(1, 16'h3000, 16'h1234, 0, 8'h00);
      do_access(0, 16'h3000, 16'hBEEF, 0, 8'h00);

      // Consecutive reads with ready stuck high
      do_access(1, 16'h3000, 16'h1111, 0, 8'h00);
      do_access(1, 16'h3001, 16'h2222, 0, 8'h00);
      ram_mode = 2;
      do_access(0, 16'h3000, 16'h0000, 0, 8'h00);
      do_access(0, 16'h3001, 16'h0000, 0, 8'h00);
      ram_mode = 0;

      // Timeout
      ram_mode = 1;
      do_access(0, 16'h3002, 16'h7777, 0, 8'h00);
      ram_mode = 0;

      // Keyboard
      kb_strobe(8'h41);
      do_access(1, IO_BASE, 16'h4000, 0, 8'h00);
      do_access(0, IO_BASE + 16'd2, 16'h0000, 0, 8'h00);
      do_access(0, IO_BASE, 16'h0000, 0, 8'h00);
      kb_strobe(8'h42);
      do_access(0, IO_BASE + 16'd2, 16'h0000, 1, 8'h43);
      do_access(0, IO_BASE, 16'h0000, 0, 8'h00);
      do_access(0, IO_BASE + 16'd2, 16'h0000, 0, 8'h00);

      // Display
      do_access(1, IO_BASE + 16'd6, 16'h0058, 0, 8'h00);
      do_access(0, IO_BASE + 16'd4, 16'hFFFF, 0, 8'h00);
      disp_ack();
      check_io_outs("ack");
      do_access(0, IO_BASE + 16'd4, 16'h0000, 0, 8'h00);
      disp_ack();
      check_io_outs("ack_idle");

      // Boundary: last RAM address vs first I/O address
      do_access(1, 16'hFDFF, 16'hA5A5, 0, 8'h00);
      do_access(0, 16'hFDFF, 16'h0000, 0, 8'h00);

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 9))
            0, 1: do_access(1, pick_ram_addr(), 16'($urandom), 0, 8'h00);
            2, 3: begin
               ram_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
               do_access(0, pick_ram_addr(), 16'($urandom), 0, 8'h00);
               ram_mode = 0;
            end
            4: do_access(1, pick_io_addr(), 16'($urandom), 0, 8'h00);
            5, 6: do_access(0, pick_io_addr(), 16'($urandom), $urandom_range(0, 3) == 0,
                            8'($urandom));
            7: kb_strobe(8'($urandom));
            8: begin disp_ack(); check_io_outs("rnd_ack"); end
            default: begin
               if ($urandom_range(0, 3) == 0) begin
                  ram_mode = 1;
                  do_access(0, pick_ram_addr(), 16'($urandom), 0, 8'h00);
                  ram_mode = 0;
               end else begin
                  do_access(0, pick_ram_addr(), 16'($urandom), 0, 8'h00);
               end
            end
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
